memory_array_ctrl: RTL and testbench

MEMORY_ARRAY_CTRL -- requirements
Module: memory_array_ctrl

---
 rtl/memory_array_pkg.sv | 21 ++
 rtl/memory_array_ctrl_arb.sv | 30 +++
 rtl/memory_array_ctrl.sv | 161 ++++++++++++++++
 tb/tb_memory_array_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_array_pkg.sv
// memory_array_pkg: FSM state encoding and default geometry for memory_array_ctrl.
// The verify states exist only when MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN is defined.
package memory_array_pkg;

  localparam int DEF_WORDS = 16;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
`ifdef MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN
    ,
    S_VSETUP,
    S_VSTROBE,
    S_VHOLD
`endif
  } state_e;

endpackage

// File: rtl/memory_array_ctrl_arb.sv
// rr_arbiter2: two-way round-robin arbiter. The grant is combinational from
// req; the last-grant pointer moves only when the granted request is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last;  // 1 = requester 1 was granted most recently

  // Lone requester wins; on contention the one not served last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last <= 1'b1;
    else if (advance) last <= gnt[1];
  end

endmodule

// File: rtl/memory_array_ctrl.sv
// memory_array_ctrl: serialises two requesters onto a bitcell word array with a
// SETUP / STROBE / HOLD access sequence. Defining MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN
// adds a readback of every write and reports mismatches on rsp_err.
module memory_array_ctrl
  import memory_array_pkg::*;
#(
  parameter int WORDS = DEF_WORDS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_we,
  input  logic [2*AW-1:0]    req_addr,
  input  logic [2*WIDTH-1:0] req_wdata,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic [WORDS-1:0]   arr_sel,
  output logic               arr_rw,
  output logic [WIDTH-1:0]   arr_wdata,
  input  logic [WIDTH-1:0]   arr_rdata,
  output logic               busy
);

  state_e           state;
  logic             armed;     // low for the first cycle after reset release
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [1:0]       gnt;
  logic             xfer;
  logic             xid;
  logic             we_mux;
  logic [AW-1:0]    addr_mux;
  logic [WIDTH-1:0] wdata_mux;
  logic             in_range;
  logic [WORDS-1:0] sel_dec;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (xfer),
    .gnt     (gnt)
  );

  // The grant is a subset of req_valid, so any ready bit is a transfer.
  assign req_ready = (armed && state == S_IDLE) ? gnt : 2'b00;
  assign xfer      = |req_ready;
  assign xid       = req_ready[1];
  assign busy      = (state != S_IDLE);

  assign we_mux    = xid ? req_we[1]            : req_we[0];
  assign addr_mux  = xid ? req_addr[AW +: AW]   : req_addr[0 +: AW];
  assign wdata_mux = xid ? req_wdata[WIDTH +: WIDTH] : req_wdata[0 +: WIDTH];

  // Addresses past the array are serviced but never select a word.
  assign in_range = (32'(addr_q) < WORDS);

  // One-hot word select for the latched address (all zero when out of range).
  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < WORDS; i++) sel_dec[i] = (32'(addr_q) == i);
  end

`ifdef MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN
  logic [WIDTH-1:0] wdata_q;
  logic             err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Access sequencer. All array and response outputs are registered; arr_rw
  // only moves on edges where arr_sel is already zero, and the async reset
  // clears arr_sel together with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      arr_sel   <= '0;
      arr_rw    <= 1'b0;
      arr_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rdata <= '0;
`ifdef MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN
      wdata_q   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      armed     <= 1'b1;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            state     <= S_SETUP;
            we_q      <= we_mux;
            addr_q    <= addr_mux;
            rsp_id    <= xid;
            arr_rw    <= we_mux;
            arr_wdata <= we_mux ? wdata_mux : '0;
`ifdef MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN
            wdata_q   <= wdata_mux;
`endif
          end
        end
        S_SETUP: begin
          state   <= S_STROBE;
          arr_sel <= sel_dec;
        end
        S_STROBE: begin
          state     <= S_HOLD;
          arr_sel   <= '0;
          rsp_rdata <= (!we_q && in_range) ? arr_rdata : '0;
`ifdef MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN
          rsp_valid <= !we_q;  // writes respond after the readback
          err_q     <= 1'b0;
`else
          rsp_valid <= 1'b1;
`endif
        end
        S_HOLD: begin
`ifdef MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN
          if (we_q) begin
            state  <= S_VSETUP;
            arr_rw <= 1'b0;
          end else begin
            state  <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end
`ifdef MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN
        S_VSETUP: begin
          state   <= S_VSTROBE;
          arr_sel <= sel_dec;
        end
        S_VSTROBE: begin
          state     <= S_VHOLD;
          arr_sel   <= '0;
          rsp_valid <= 1'b1;
          err_q     <= in_range && (arr_rdata != wdata_q);
        end
        S_VHOLD: begin
          state <= S_IDLE;
          err_q <= 1'b0;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_array_ctrl.sv
// tb_memory_array_ctrl: scoreboard bench. A behavioural model predicts grants
// and responses from the request stream; a monitor pops expected responses
// whenever rsp_valid is seen. A simple bitcell array model sits on arr_*.
module tb_memory_array_ctrl;

  localparam int WORDS = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 5;   // wide enough to present out-of-range addresses
`ifdef MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN
  localparam int WLAT  = 6;
`else
  localparam int WLAT  = 3;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [1:0]         req_valid, req_ready, req_we;
  logic [2*AW-1:0]    req_addr;
  logic [2*WIDTH-1:0] req_wdata;
  logic               rsp_valid, rsp_id, rsp_err, arr_rw, busy;
  logic [WIDTH-1:0]   rsp_rdata, arr_wdata, arr_rdata;
  logic [WORDS-1:0]   arr_sel;

  memory_array_ctrl #(.WORDS(WORDS), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .arr_sel(arr_sel), .arr_rw(arr_rw), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, got, exp, $time);
    else n_pass++;
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: event did not occur within its cycle budget", nm);
  endtask

  // ---------------- bitcell array model (bit mask 'stuck' reads back 0) ----
  logic [WIDTH-1:0] mem_arr [WORDS] = '{default: '0};
  logic [WIDTH-1:0] stuck = '0;

  always_comb begin
    arr_rdata = '0;
    for (int i = 0; i < WORDS; i++) if (arr_sel[i]) arr_rdata = arr_rdata | mem_arr[i];
  end

  always @(posedge clk)
    if (arr_rw) for (int j = 0; j < WORDS; j++) if (arr_sel[j]) mem_arr[j] <= arr_wdata & ~stuck;

  // ---------------- reference model ----------------------------------------
  typedef struct { int due; bit id; logic [WIDTH-1:0] rdata; bit err; } exp_t;
  exp_t q[$];
  logic [WIDTH-1:0] ref_mem [WORDS] = '{default: '0};

  int   cyc = 0;
  logic [1:0] acc = '0;   // handshakes completed at the latest edge
  bit   armed_m = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    acc <= req_valid & req_ready;
  end
  always @(posedge clk or negedge rst_n) armed_m <= rst_n;

  bit   last_m = 1;
  int   busy_from = -100, busy_until = -100, strb_cyc = -100, vstrb_cyc = -100;
  int   strb_addr = 0;
  bit   strb_we = 0;
  logic [WIDTH-1:0] strb_wd = '0;
  bit   pend = 0;
  int   pend_addr = 0, pend_commit = 0;
  logic [WIDTH-1:0] pend_old = '0;
  bit   idle_m, pick, m_we;
  int   m_a, m_lat;
  logic [WIDTH-1:0] m_wd;
  logic [1:0] exp_rdy;
  logic [WORDS-1:0] exp_sel;
  exp_t e_p;

  // Predictor: per-cycle expected handshake and array activity; on a predicted
  // accept, apply the access to ref_mem and queue the expected response.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (pend && cyc < pend_commit) ref_mem[pend_addr] = pend_old;  // aborted write
      pend = 0; q.delete(); last_m = 1;
      busy_from = -100; busy_until = -100; strb_cyc = -100; vstrb_cyc = -100;
    end else begin
      idle_m = !(cyc >= busy_from && cyc <= busy_until);
      chk("busy", 32'(busy), 32'(!idle_m));
      exp_sel = '0;
      if ((cyc == strb_cyc || cyc == vstrb_cyc) && strb_addr < WORDS) exp_sel[strb_addr] = 1'b1;
      chk("arr_sel", 32'(arr_sel), 32'(exp_sel));
      if (cyc == strb_cyc) begin
        chk("arr_rw", 32'(arr_rw), 32'(strb_we));
        chk("arr_wdata", 32'(arr_wdata), strb_we ? 32'(strb_wd) : 32'h0);
      end
      if (cyc == vstrb_cyc) chk("arr_rw_verify", 32'(arr_rw), 32'h0);
      exp_rdy = 2'b00;
      if (armed_m && idle_m && req_valid != 2'b00) begin
        pick = (req_valid == 2'b11) ? !last_m : req_valid[1];
        exp_rdy[pick] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_rdy != 2'b00) begin
        last_m = pick;
        m_we = req_we[pick];
        m_a  = int'(req_addr[pick*AW +: AW]);
        m_wd = req_wdata[pick*WIDTH +: WIDTH];
        e_p.id = pick; e_p.rdata = '0; e_p.err = 0;
        if (m_we) begin
          m_lat = WLAT;
          if (m_a < WORDS) begin
            pend = 1; pend_addr = m_a; pend_old = ref_mem[m_a]; pend_commit = cyc + 3;
            ref_mem[m_a] = m_wd & ~stuck;
`ifdef MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN
            e_p.err = ((m_wd & stuck) != '0);
`endif
          end
        end else begin
          m_lat = 3;
          e_p.rdata = (m_a < WORDS) ? ref_mem[m_a] : '0;
        end
        e_p.due = cyc + m_lat;
        q.push_back(e_p);
        busy_from = cyc + 1; busy_until = cyc + m_lat;
        strb_cyc = cyc + 2;  vstrb_cyc = (m_lat == 6) ? cyc + 5 : -100;
        strb_addr = m_a; strb_we = m_we; strb_wd = m_wd;
      end
    end
  end

  exp_t e_m;
  // Monitor: every rsp_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 want 0 (cyc %0d)", cyc);
        end else begin
          e_m = q.pop_front();
          chk("rsp_latency_cycle", 32'(cyc), 32'(e_m.due));
          chk("rsp_id", 32'(rsp_id), 32'(e_m.id));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e_m.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(e_m.err));
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        e_m = q.pop_front();
        chk("rsp_valid_missing", 32'(rsp_valid), 32'h1);
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic drive(input int r, input int we, input int addr, input int wd);
    req_valid[r] = 1'b1;
    req_we[r]    = 1'(we);
    req_addr[r*AW +: AW]       = AW'(addr);
    req_wdata[r*WIDTH +: WIDTH] = WIDTH'(wd);
  endtask

  task automatic wait_acc(input int r);
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(posedge clk); #1;
      if (acc[r]) ok = 1;
    end
    req_valid[r] = 1'b0;
    if (!ok) fail_now("accept_timeout");
  endtask

  int who[8], at[8], n_acc;
  bit ok_f;

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    drive(0, 0, 1, 0); drive(1, 0, 2, 0);   // both requesting through reset
    repeat (2) @(posedge clk); #1;
    chk("rst_arr_sel", 32'(arr_sel), 32'h0);
    chk("rst_arr_rw", 32'(arr_rw), 32'h0);
    chk("rst_arr_wdata", 32'(arr_wdata), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    #1 rst_n = 1'b1;

    // Contention: grants alternate 0,1,0,1 spaced 4 cycles apart.
    n_acc = 0;
    for (int k = 0; k < 80 && n_acc < 8; k++) begin
      @(posedge clk); #1;
      if (acc != 2'b00) begin
        who[n_acc] = int'(acc[1]); at[n_acc] = cyc; n_acc++;
        drive(int'(acc[1]), 0, $urandom_range(0, 15), 0);
      end
    end
    req_valid = '0;
    if (n_acc < 8) fail_now("contention_accepts");
    for (int k = 0; k < n_acc; k++) begin
      chk("rr_order", 32'(who[k]), 32'(k % 2));
      if (k > 0) chk("rr_spacing", 32'(at[k] - at[k-1]), 32'd4);
    end

    // Write then read back on requester 0.
    drive(0, 1, 3, 8'hA5); wait_acc(0);
    drive(0, 0, 3, 0);     wait_acc(0);
    // Out of range: write to 20 must not alias word 4; read of 20 returns 0.
    drive(1, 1, 20, 8'h3C); wait_acc(1);
    drive(1, 0, 20, 0);     wait_acc(1);
    drive(1, 0, 4, 0);      wait_acc(1);

    // Reset during STROBE of a write aborts it.
    drive(0, 1, 5, 8'hFF); wait_acc(0);
    ok_f = 0;
    for (int k = 0; k < 10 && !ok_f; k++) begin
      @(posedge clk); #1;
      if (arr_sel != '0) ok_f = 1;
    end
    if (!ok_f) fail_now("strobe_not_seen");
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_arr_sel", 32'(arr_sel), 32'h0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    drive(0, 0, 5, 0); drive(1, 0, 6, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    ok_f = 0;
    for (int k = 0; k < 20 && !ok_f; k++) begin
      @(posedge clk); #1;
      if (acc != 2'b00) begin ok_f = 1; chk("post_rst_first_grant", 32'(acc), 32'h1); end
    end
    if (!ok_f) fail_now("post_rst_accept");
    req_valid[0] = 1'b0;
    wait_acc(1);

`ifdef MEMORY_ARRAY_CTRL_WRITE_VERIFY_EN
    // Bit 0 stuck at 0: writing 0x01 must flag, 0x02 must not.
    repeat (8) @(posedge clk); #1;
    stuck = 8'h01;
    drive(0, 1, 2, 8'h01); wait_acc(0);
    drive(0, 1, 7, 8'h02); wait_acc(0);
    drive(0, 0, 2, 0);     wait_acc(0);
    repeat (8) @(posedge clk); #1;
    stuck = '0;
`endif

    // Randomised traffic, including requests withdrawn before acceptance.
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) req_valid[r] = 1'b0;
        if (!req_valid[r]) begin
          if ($urandom_range(0, 2) == 0)
            drive(r, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 255));
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
    end
    req_valid = '0;
    repeat (12) @(posedge clk); #1;
    chk("drain_outstanding", 32'(q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within its time budget");
    $fatal(1);
  end

endmodule
